// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: register numbers and stage control flags in, stall/flush/forward selects out.
// Purely combinational wiring; no flow control of its own.
interface hazard_ctrl_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, JumpRegD;
  logic       MdStartE, MdIsDivE, MdAccessD;
  logic       InterruptRequest;
  logic       StallF, StallD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       MdBusy;
  logic [3:0] MdCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, MdStartE, MdIsDivE, MdAccessD, InterruptRequest,
    input  StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           MdBusy, MdCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, MdStartE, MdIsDivE, MdAccessD, InterruptRequest,
    output StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           MdBusy, MdCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: load-use/branch/mult-div stalls, EX/ID forwarding, MDU busy tracker.
// Stall/flush/forward are same-cycle combinational; MdBusy/MdCount are registered; it never applies backpressure itself.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  md_state_t  r_state;
  logic [3:0] r_count;

  logic       w_lwstall, w_brstall, w_mdstall, w_stall, w_flush;
  logic [1:0] w_fae, w_fbe;
  logic       w_fad, w_fbd;

  // r0 is hardwired zero, so it can never be a real dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] ex_fwd(input logic [4:0] src,
                                        input logic rw_m, input logic [4:0] wr_m,
                                        input logic rw_w, input logic [4:0] wr_w);
    if (rw_m && reg_match(wr_m, src))      return 2'b10;
    else if (rw_w && reg_match(wr_w, src)) return 2'b01;
    else                                   return 2'b00;
  endfunction

  always_comb begin
    w_lwstall = hif.MemtoRegE && hif.RegWriteE &&
                (reg_match(hif.WriteRegE, hif.RsD) || reg_match(hif.WriteRegE, hif.RtD));
    w_brstall = (hif.BranchD || hif.JumpRegD) &&
                ((hif.RegWriteE && (reg_match(hif.WriteRegE, hif.RsD) ||
                                    reg_match(hif.WriteRegE, hif.RtD))) ||
                 (hif.MemtoRegM && (reg_match(hif.WriteRegM, hif.RsD) ||
                                    reg_match(hif.WriteRegM, hif.RtD))));
    // a start in EX this cycle already occupies the unit for the ID instruction
    w_mdstall = hif.MdAccessD && ((r_state == BUSY) || hif.MdStartE);
    w_fae     = ex_fwd(hif.RsE, hif.RegWriteM, hif.WriteRegM, hif.RegWriteW, hif.WriteRegW);
    w_fbe     = ex_fwd(hif.RtE, hif.RegWriteM, hif.WriteRegM, hif.RegWriteW, hif.WriteRegW);
    w_fad     = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RsD);
    w_fbd     = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RtD);
    w_stall   = w_lwstall || w_brstall || w_mdstall;
    w_flush   = w_stall || hif.InterruptRequest;
  end

  // Reset forces a bubble into EX and suppresses stalls/forwarding
  assign hif.StallF    = reset && w_stall;
  assign hif.StallD    = reset && w_stall;
  assign hif.FlushE    = !reset || w_flush;
  assign hif.ForwardAE = reset ? w_fae : 2'b00;
  assign hif.ForwardBE = reset ? w_fbe : 2'b00;
  assign hif.ForwardAD = reset && w_fad;
  assign hif.ForwardBD = reset && w_fbd;
  assign hif.MdBusy    = (r_state == BUSY);
  assign hif.MdCount   = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hif.MdStartE) begin
            r_count <= hif.MdIsDivE ? DIV_N : MULT_N;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_count <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles of the multiply unit after a start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles of the divide unit after a start.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 RsD, RtD  input  5 each  source registers of the instruction in ID.
REQ-006 RsE, RtE  input  5 each  source registers held in the ID/EX register.
REQ-007 WriteRegE, WriteRegM, WriteRegW  input  5 each  destination register in EX/MEM/WB.
REQ-008 RegWriteE, RegWriteM, RegWriteW  input  1 each  the stage writes the register file.
REQ-009 MemtoRegE, MemtoRegM  input  1 each  the stage holds a load.
REQ-010 BranchD, JumpRegD  input  1 each  the ID instruction compares or uses registers in ID.
REQ-011 MdStartE  input  1  mult/div issues from EX this cycle.
REQ-012 MdIsDivE  input  1  qualifies MdStartE: 1 = divide, 0 = multiply.
REQ-013 MdAccessD  input  1  the ID instruction is a mult/div/mfhi/mflo/mthi/mtlo.
REQ-014 InterruptRequest  input  1  interrupt entry; squash EX.
REQ-015 StallF, StallD  output  1 each  hold PC and the IF/ID register.
REQ-016 FlushE  output  1  clear the ID/EX register.
REQ-017 ForwardAE, ForwardBE  output  2 each  EX operand select: 00 = RD1E/RD2E, 01 = WB result, 10 = MEM ALU result.
REQ-018 ForwardAD, ForwardBD  output  1 each  ID comparator operand from the MEM ALU result.
REQ-019 MdBusy  output  1  mult/div unit is busy.
REQ-020 MdCount  output  4  remaining busy cycles.

Function
REQ-021 A register match SHALL require a nonzero register number; register 0 never matches, stalls, or forwards.
REQ-022 lwstall SHALL be 1 when MemtoRegE & RegWriteE & WriteRegE matches RsD or RtD.
REQ-023 brstall SHALL be 1 when (BranchD | JumpRegD) and either:
- RegWriteE & WriteRegE matches RsD/RtD; or
- MemtoRegM & WriteRegM matches RsD/RtD.
REQ-024 mdstall SHALL be 1 when MdAccessD & (MdBusy | MdStartE).
REQ-025 StallF = StallD SHALL be lwstall | brstall | mdstall, combinationally in the same cycle.
REQ-026 FlushE SHALL be lwstall | brstall | mdstall | InterruptRequest.
REQ-027 InterruptRequest SHALL NOT assert StallF/StallD.
REQ-028 ForwardAE SHALL be:
- 10 if RegWriteM & WriteRegM matches RsE;
- otherwise 01 if RegWriteW & WriteRegW matches RsE;
- otherwise 00.
- The MEM stage has priority when both match.
REQ-029 ForwardBE SHALL use the same rule as REQ-028 with RtE.
REQ-030 ForwardAD/ForwardBD SHALL be RegWriteM & WriteRegM matching RsD/RtD respectively.
REQ-031 The MDU tracker SHALL be a two-state FSM, IDLE (MdCount = 0) and BUSY (MdCount != 0); MdBusy = (state == BUSY).
REQ-032 In IDLE with MdStartE = 1, MdCount SHALL load DIV_CYCLES if MdIsDivE = 1, else MULT_CYCLES, and the FSM enters BUSY on the next edge.
REQ-033 In BUSY, MdCount SHALL decrement by 1 per cycle; the FSM returns to IDLE on the edge where the count reaches 0.
- MdBusy is therefore 1 for exactly N cycles after the start edge.
REQ-034 MdStartE in BUSY SHALL be ignored; the count continues unchanged in sequence.
REQ-035 InterruptRequest and stalls SHALL NOT abort or pause the MDU count.
REQ-036 Parameters SHALL be in the range 1..15; MdCount is 4 bits wide and never wraps.

Reset
REQ-037 While reset = 0 at a posedge, the next state SHALL be IDLE with MdCount = 0 and MdBusy = 0, including mid-BUSY.
REQ-038 While reset = 0, outputs SHALL be:
- StallF = StallD = 0;
- FlushE = 1;
- all Forward outputs = 0.
REQ-039 Once reset = 1, the block SHALL operate normally from the first following edge.

Verification
REQ-040 Load-use: MemtoRegE = RegWriteE = 1, WriteRegE = 8, RsD = 8 -> StallF = StallD = FlushE = 1 for that cycle. Repeating with WriteRegE = 0 -> all three 0.
REQ-041 Forward priority: RegWriteM = RegWriteW = 1, WriteRegM = WriteRegW = RsE = 5 -> ForwardAE = 10. Then RegWriteM = 0 -> ForwardAE = 01.
REQ-042 Branch hazard: BranchD = 1, RsD = 3, and:
- RegWriteE = 1, WriteRegE = 3 -> StallD = 1, ForwardAD = 0;
- next, MEM ALU result with WriteRegM = 3 (not a load) -> StallD = 0, ForwardAD = 1.
REQ-043 Divide: MdStartE = MdIsDivE = 1 for one cycle -> MdBusy = 1 for 10 cycles (MdCount 10..1), then 0. MdAccessD = 1 throughout -> StallD = 1 during the start cycle and all 10 busy cycles.
REQ-044 Reset mid-operation: multiply started, reset = 0 at count 3 -> MdCount = 0, MdBusy = 0, FlushE = 1. A second MdStartE during BUSY (no reset) -> count unaffected.
REQ-045 Interrupt: InterruptRequest = 1 with no hazards -> FlushE = 1, StallF = StallD = 0, MdCount keeps decrementing.
